// File: rtl/seg_scan_ctrl_if.sv
// Bus bundle for the eight-digit seven-segment scan controller.
// The master side supplies display data and the load strobe; the slave
// side (the controller) returns the digit select, segment/anode drive
// and the frame/pending status flags.
interface seg_scan_ctrl_if;
   logic        load;
   logic [31:0] data;
   logic [7:0]  digit_en;
   logic [7:0]  dp_in;
   logic [2:0]  sel;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp_n;
   logic        frame_done;
   logic        busy_pend;

   modport master (
      output load, data, digit_en, dp_in,
      input  sel, an, seg, dp_n, frame_done, busy_pend
   );

   modport slave (
      input  load, data, digit_en, dp_in,
      output sel, an, seg, dp_n, frame_done, busy_pend
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display.
// Each digit slot lasts REFRESH_DIV cycles: BLANK_CYC cycles with every
// anode off (dead time against ghosting), then the digit is shown.
// Display data is double-buffered: a load lands in a pending buffer that
// is copied to the active buffer only when the scan wraps from digit 7 to
// digit 0, so a frame never mixes old and new digits.
// Anode/segment/dp outputs are registered and trail the scan state by one
// cycle.
module seg_scan_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 1000,
   parameter int CNT_W       = 17
) (
   input  logic               clk,
   input  logic               rst_n,
   seg_scan_ctrl_if.slave     bus
);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

   // scan state
   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [2:0]       sel;
   logic [2:0]       sel_nx;
   logic             frame_end;

   // display buffers
   logic [31:0]      act_data;
   logic [7:0]       act_en;
   logic [7:0]       act_dp;
   logic [31:0]      pend_data;
   logic [7:0]       pend_en;
   logic [7:0]       pend_dp;
   logic             busy;

   // output decode and its register stage
   logic [3:0]       nib;
   logic [7:0]       an_p0;
   logic [6:0]       seg_p0;
   logic             dp_n_p0;
   logic [7:0]       an_p1;
   logic [6:0]       seg_p1;
   logic             dp_n_p1;
   logic             frame_done_p1;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
   function automatic logic [6:0] hex2seg(input logic [3:0] hex);
      logic [6:0] pat;
      case (hex)
         4'h0:    pat = 7'h40;
         4'h1:    pat = 7'h79;
         4'h2:    pat = 7'h24;
         4'h3:    pat = 7'h30;
         4'h4:    pat = 7'h19;
         4'h5:    pat = 7'h12;
         4'h6:    pat = 7'h02;
         4'h7:    pat = 7'h78;
         4'h8:    pat = 7'h00;
         4'h9:    pat = 7'h10;
         4'hA:    pat = 7'h08;
         4'hB:    pat = 7'h03;
         4'hC:    pat = 7'h46;
         4'hD:    pat = 7'h21;
         4'hE:    pat = 7'h06;
         default: pat = 7'h0E;
      endcase
      return pat;
   endfunction

   // Scan state register: slot phase, slot counter and digit select.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= BLANK;
         cnt   <= '0;
         sel   <= 3'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         sel   <= sel_nx;
      end
   end

   // Next-state logic plus decode of what the display should show now.
   // The counter runs through the whole slot; only the phase changes at
   // the end of the dead time, and the slot end advances the digit.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt + 1'b1;
      sel_nx    = sel;
      frame_end = 1'b0;
      an_p0     = 8'hFF;
      seg_p0    = 7'h7F;
      dp_n_p0   = 1'b1;
      nib       = act_data[{sel, 2'b00} +: 4];

      case (state)
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_nx = SHOW;
            end
         end
         SHOW: begin
            if (act_en[sel]) begin
               an_p0   = 8'(~(8'h01 << sel));
               seg_p0  = hex2seg(nib);
               dp_n_p0 = ~act_dp[sel];
            end
            if (cnt == SLOT_LAST) begin
               cnt_nx    = '0;
               state_nx  = BLANK;
               sel_nx    = sel + 3'd1;
               frame_end = (sel == 3'd7);
            end
         end
         default: begin
            state_nx = BLANK;
            cnt_nx   = '0;
         end
      endcase
   end

   // Double buffer: loads fill pending; the frame boundary commits it.
   // A load that coincides with the boundary bypasses pending entirely.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         act_data  <= '0;
         act_en    <= '0;
         act_dp    <= '0;
         pend_data <= '0;
         pend_en   <= '0;
         pend_dp   <= '0;
         busy      <= 1'b0;
      end else if (frame_end && bus.load) begin
         act_data  <= bus.data;
         act_en    <= bus.digit_en;
         act_dp    <= bus.dp_in;
         busy      <= 1'b0;
      end else if (frame_end && busy) begin
         act_data  <= pend_data;
         act_en    <= pend_en;
         act_dp    <= pend_dp;
         busy      <= 1'b0;
      end else if (bus.load) begin
         pend_data <= bus.data;
         pend_en   <= bus.digit_en;
         pend_dp   <= bus.dp_in;
         busy      <= 1'b1;
      end
   end

   // ---- stage p0 -> p1: register the display drive and frame pulse ----
   // Output register stage for anodes, segments, dp and the frame pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_p1         <= 8'hFF;
         seg_p1        <= 7'h7F;
         dp_n_p1       <= 1'b1;
         frame_done_p1 <= 1'b0;
      end else begin
         an_p1         <= an_p0;
         seg_p1        <= seg_p0;
         dp_n_p1       <= dp_n_p0;
         frame_done_p1 <= frame_end;
      end
   end

   assign bus.sel        = sel;
   assign bus.an         = an_p1;
   assign bus.seg        = seg_p1;
   assign bus.dp_n       = dp_n_p1;
   assign bus.frame_done = frame_done_p1;
   assign bus.busy_pend  = busy;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a short slot (8 cycles, 2 blanked) so one
// frame is 64 cycles. Display vectors come from a table; the expected
// per-digit drive is queued when a load is issued and popped as each
// digit slot of the committed frame is observed.
module tb_seg_scan_ctrl;

   localparam int RDIV  = 8;
   localparam int BCYC  = 2;
   localparam int CW    = 3;
   localparam int NVEC  = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   seg_scan_ctrl_if bus_if ();

   seg_scan_ctrl #(
      .REFRESH_DIV (RDIV),
      .BLANK_CYC   (BCYC),
      .CNT_W       (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   typedef struct {
      logic [31:0] data;
      logic [7:0]  en;
      logic [7:0]  dp;
      logic [55:0] seg;   // digit k pattern at [7k +: 7]
   } vec_t;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp_n;
   } exp_t;

   vec_t tbl [NVEC];
   exp_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input int tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0d: got %0h, want %0h", name, tag, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] en, input logic [7:0] dp,
                           input logic [55:0] segs);
      exp_t e;
      for (int k = 0; k < 8; k++) begin
         e.an   = en[k] ? 8'(~(8'h01 << k)) : 8'hFF;
         e.seg  = segs[7*k +: 7];
         e.dp_n = en[k] ? ~dp[k] : 1'b1;
         sb.push_back(e);
      end
   endtask

   task automatic drive_load(input logic [31:0] d, input logic [7:0] en,
                             input logic [7:0] dp);
      bus_if.load     = 1'b1;
      bus_if.data     = d;
      bus_if.digit_en = en;
      bus_if.dp_in    = dp;
   endtask

   // Step negedges until frame_done is seen; a missing pulse is a failure.
   task automatic wait_frame(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus_if.frame_done !== 1'b1 && cyc < 200);
      if (bus_if.frame_done !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL frame_wait: no frame_done within %0d cycles", cyc);
      end
   endtask

   // Called on the frame_done cycle; checks the 64 cycles that follow.
   // Cycles 8k+1..8k+2 are the dead time of slot k, 8k+3..8k+8 show it.
   task automatic check_frame();
      exp_t e;
      e.an   = 8'h00;
      e.seg  = 7'h00;
      e.dp_n = 1'b0;
      for (int t = 1; t <= 64; t++) begin
         int j;
         int k;
         @(negedge clk);
         j = (t - 1) % 8;
         k = (t - 1) / 8;
         chk("frame_done", t, 32'(bus_if.frame_done), 32'(t == 64));
         chk("one_anode", t, 32'($countones(~bus_if.an) <= 1), 32'd1);
         if (j < 2) begin
            chk("blank_an", t, 32'(bus_if.an), 32'hFF);
            chk("blank_seg", t, 32'(bus_if.seg), 32'h7F);
            chk("blank_dp", t, 32'(bus_if.dp_n), 32'd1);
         end else begin
            if (j == 2) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL scoreboard_empty @%0d", t);
                  e.an   = 8'h00;
                  e.seg  = 7'h00;
                  e.dp_n = 1'b0;
               end else begin
                  e = sb.pop_front();
               end
               chk("sel", t, 32'(bus_if.sel), 32'(k));
               chk("busy_idle", t, 32'(bus_if.busy_pend), 32'd0);
            end
            chk("an", t, 32'(bus_if.an), 32'(e.an));
            chk("seg", t, 32'(bus_if.seg), 32'(e.seg));
            chk("dp_n", t, 32'(bus_if.dp_n), 32'(e.dp_n));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;

      tbl[0] = '{data: 32'hFEDCBA98, en: 8'hFF, dp: 8'hFF,
                 seg: {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}};
      tbl[1] = '{data: 32'h76543210, en: 8'h05, dp: 8'h04,
                 seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h7F, 7'h40}};
      tbl[2] = '{data: 32'h00000000, en: 8'h80, dp: 8'h80,
                 seg: {7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}};
      tbl[3] = '{data: 32'h76543210, en: 8'hFF, dp: 8'h00,
                 seg: {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}};

      rst_n           = 1'b0;
      bus_if.load     = 1'b0;
      bus_if.data     = '0;
      bus_if.digit_en = '0;
      bus_if.dp_in    = '0;

      // Reset held for three cycles.
      repeat (3) @(negedge clk);
      chk("rst_an", 0, 32'(bus_if.an), 32'hFF);
      chk("rst_seg", 0, 32'(bus_if.seg), 32'h7F);
      chk("rst_dp", 0, 32'(bus_if.dp_n), 32'd1);
      chk("rst_sel", 0, 32'(bus_if.sel), 32'd0);
      chk("rst_frame", 0, 32'(bus_if.frame_done), 32'd0);
      chk("rst_busy", 0, 32'(bus_if.busy_pend), 32'd0);
      rst_n = 1'b1;

      // First frame after reset: nothing enabled, full 64-cycle frame.
      wait_frame(cyc);
      chk("first_frame_len", cyc, 32'(cyc), 32'd64);

      // Table vectors: load, wait one frame for the commit, check the next.
      for (int i = 0; i < NVEC; i++) begin
         drive_load(tbl[i].data, tbl[i].en, tbl[i].dp);
         push_exp(tbl[i].en, tbl[i].dp, tbl[i].seg);
         @(negedge clk);
         bus_if.load = 1'b0;
         chk("busy_set", i, 32'(bus_if.busy_pend), 32'd1);
         wait_frame(cyc);
         chk("commit_len", i, 32'(cyc), 32'd63);
         chk("busy_clr", i, 32'(bus_if.busy_pend), 32'd0);
         check_frame();
      end

      // Double buffering: load all-F while digit 3 is shown.
      for (int t = 1; t <= 27; t++) @(negedge clk);
      chk("db_sel3", 27, 32'(bus_if.sel), 32'd3);
      chk("db_an3", 27, 32'(bus_if.an), 32'hF7);
      drive_load(32'hFFFFFFFF, 8'hFF, 8'h00);
      push_exp(8'hFF, 8'h00, {8{7'h0E}});
      for (int t = 28; t <= 64; t++) begin
         int j;
         int k;
         @(negedge clk);
         if (t == 28) bus_if.load = 1'b0;
         j = (t - 1) % 8;
         k = (t - 1) / 8;
         chk("db_busy", t, 32'(bus_if.busy_pend), 32'(t < 64));
         if (k >= 4 && j >= 2) begin
            chk("db_old_seg", t, 32'(bus_if.seg), 32'(tbl[NVEC-1].seg[7*k +: 7]));
         end
      end
      chk("db_frame", 64, 32'(bus_if.frame_done), 32'd1);
      check_frame();

      // Load landing exactly on the frame-boundary cycle.
      for (int t = 1; t <= 63; t++) @(negedge clk);
      chk("bnd_sel7", 63, 32'(bus_if.sel), 32'd7);
      drive_load(32'hAAAAAAAA, 8'hFF, 8'h00);
      push_exp(8'hFF, 8'h00, {8{7'h08}});
      @(negedge clk);
      bus_if.load = 1'b0;
      chk("bnd_frame", 64, 32'(bus_if.frame_done), 32'd1);
      chk("bnd_busy", 64, 32'(bus_if.busy_pend), 32'd0);
      check_frame();

      // Reset in the middle of slot 5 with a load pending.
      drive_load(32'h00000000, 8'h01, 8'h00);
      @(negedge clk);
      bus_if.load = 1'b0;
      for (int t = 2; t <= 44; t++) @(negedge clk);
      chk("mr_sel5", 44, 32'(bus_if.sel), 32'd5);
      chk("mr_busy", 44, 32'(bus_if.busy_pend), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mr_an", 0, 32'(bus_if.an), 32'hFF);
      chk("mr_seg", 0, 32'(bus_if.seg), 32'h7F);
      chk("mr_dp", 0, 32'(bus_if.dp_n), 32'd1);
      chk("mr_sel", 0, 32'(bus_if.sel), 32'd0);
      chk("mr_busy0", 0, 32'(bus_if.busy_pend), 32'd0);
      chk("mr_frame", 0, 32'(bus_if.frame_done), 32'd0);
      wait_frame(cyc);
      chk("mr_frame_len", cyc, 32'(cyc), 32'd64);
      // Active buffer was cleared, so the next frame stays dark.
      push_exp(8'h00, 8'h00, {8{7'h7F}});
      check_frame();
      // Re-enable digit 0 with value 0.
      drive_load(32'h00000000, 8'h01, 8'h00);
      push_exp(8'h01, 8'h00, {{7{7'h7F}}, 7'h40});
      @(negedge clk);
      bus_if.load = 1'b0;
      wait_frame(cyc);
      chk("mr_commit_len", cyc, 32'(cyc), 32'd63);
      check_frame();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
